// File: rtl/cpu_ctrl_pkg.sv
// cpu_ctrl_pkg: opcodes, ALU modes, sequencer states and the per-state strobe decode
package cpu_ctrl_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_ADD  = 4'h3;
    localparam logic [3:0] OP_SUB  = 4'h4;
    localparam logic [3:0] OP_AND  = 4'h5;
    localparam logic [3:0] OP_OR   = 4'h6;
    localparam logic [3:0] OP_JMP  = 4'h7;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] MODE_ADD = 2'd0;
    localparam logic [1:0] MODE_SUB = 2'd1;
    localparam logic [1:0] MODE_AND = 2'd2;
    localparam logic [1:0] MODE_OR  = 2'd3;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_WAIT, ST_DECODE, ST_LOAD_A, ST_LOAD_B,
        ST_EXEC, ST_WB, ST_JUMP, ST_HALT, ST_STALL
    } state_t;

    typedef struct packed {
        logic aload;
        logic bload;
        logic irload;
        logic pcload;
        logic ansload;
        logic jsm;
        logic a_select;
        logic b_select;
        logic select_mode;
        logic busy;
        logic halted;
    } ctrl_t;

    // Strobes each state drives; everything not listed stays low
    function automatic ctrl_t ctrl_for(state_t s);
        ctrl_t c;
        c             = '0;
        c.aload       = (s == ST_LOAD_A) || (s == ST_WB);
        c.bload       = (s == ST_LOAD_B);
        c.irload      = (s == ST_FETCH);
        c.pcload      = (s == ST_FETCH) || (s == ST_JUMP);
        c.ansload     = (s == ST_EXEC);
        c.jsm         = (s == ST_JUMP);
        c.a_select    = (s == ST_LOAD_A);
        c.b_select    = (s == ST_LOAD_B);
        c.select_mode = (s == ST_EXEC) || (s == ST_WB);
        c.busy        = (s != ST_IDLE) && (s != ST_HALT);
        c.halted      = (s == ST_HALT);
        return c;
    endfunction

endpackage

// File: rtl/cpu_ctrl_decoder.sv
// cpu_ctrl_decoder: maps an opcode to the state DECODE branches to, plus an illegal flag
module cpu_ctrl_decoder
    import cpu_ctrl_pkg::*;
(
    input  logic [3:0] op,
    output state_t     target,
    output logic       illegal
);

    // NOP and undefined opcodes both return to instruction fetch
    always_comb begin
        target  = (op == OP_LDA)                  ? ST_LOAD_A :
                  (op == OP_LDB)                  ? ST_LOAD_B :
                  (op >= OP_ADD && op <= OP_OR)   ? ST_EXEC   :
                  (op == OP_JMP)                  ? ST_JUMP   :
                  (op == OP_HALT)                 ? ST_HALT   : ST_FETCH;
        illegal = (op > OP_JMP) && (op != OP_HALT);
    end

endmodule

// File: rtl/cpu_control_unit.sv
// cpu_control_unit: Moore fetch/decode/execute sequencer for the 8-bit CPU datapath
// Optional CPU_CTRL_SINGLE_STEP_EN adds a Step input that releases one instruction per rising level.
module cpu_control_unit
    import cpu_ctrl_pkg::*;
#(
    parameter int OPCODE_W   = 4,
    parameter int MODE_W     = 2,
    parameter int FETCH_WAIT = 0
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic                Run,
`ifdef CPU_CTRL_SINGLE_STEP_EN
    input  logic                Step,
`endif
    input  logic [OPCODE_W-1:0] IRCU,
    output logic [MODE_W-1:0]   mode,
    output logic                Aload,
    output logic                Bload,
    output logic                IRload,
    output logic                PCload,
    output logic                ANSload,
    output logic                JSM,
    output logic                A_select,
    output logic                B_select,
    output logic                select_mode,
    output logic                Busy,
    output logic                Halted,
    output logic                Illegal
);

    state_t              state, nxt, target;
    ctrl_t               ctl;
    logic [OPCODE_W-1:0] op, op_eff;
    logic [MODE_W-1:0]   nxt_mode;
    logic [2:0]          cnt;
    logic                dec_illegal;
    logic                go;

`ifdef CPU_CTRL_SINGLE_STEP_EN
    localparam state_t ENTRY = ST_STALL;
    logic step_q;
    assign go = Step & ~step_q;
    // Remember last Step so only a low-to-high change releases a stalled fetch
    always_ff @(posedge Clk) begin
        step_q <= Reset ? 1'b0 : Step;
    end
`else
    localparam state_t ENTRY = ST_FETCH;
    assign go = 1'b1;
`endif

    cpu_ctrl_decoder u_dec (
        .op      (4'(IRCU)),
        .target  (target),
        .illegal (dec_illegal)
    );

    // In DECODE the opcode is still on IRCU; afterwards only the latched copy counts
    assign op_eff = (state == ST_DECODE) ? IRCU : op;

    // Next-state selection and the ALU mode that goes with it
    always_comb begin
        nxt = ST_IDLE;
        case (state)
            ST_IDLE:   nxt = Run ? ENTRY : ST_IDLE;
            ST_STALL:  nxt = go ? ST_FETCH : ST_STALL;
            ST_FETCH:  nxt = (FETCH_WAIT > 0) ? ST_WAIT : ST_DECODE;
            ST_WAIT:   nxt = (cnt == 3'(FETCH_WAIT - 1)) ? ST_DECODE : ST_WAIT;
            ST_DECODE: nxt = (target == ST_FETCH) ? ENTRY : target;
            ST_EXEC:   nxt = ST_WB;
            ST_HALT:   nxt = ST_HALT;
            ST_LOAD_A, ST_LOAD_B, ST_WB, ST_JUMP: nxt = ENTRY;
            default:   nxt = ST_IDLE;
        endcase
        nxt_mode = (nxt == ST_EXEC || nxt == ST_WB) ? MODE_W'(op_eff - OPCODE_W'(3)) : '0;
    end

    // Single state register; strobes are registered from the next state so they track state exactly
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state   <= ST_IDLE;
            ctl     <= '0;
            mode    <= '0;
            op      <= '0;
            Illegal <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= nxt;
            ctl   <= ctrl_for(nxt);
            mode  <= nxt_mode;
            cnt   <= (state == ST_WAIT) ? cnt + 3'd1 : '0;
            if (state == ST_DECODE) op <= IRCU;
            if (state == ST_DECODE && dec_illegal) Illegal <= 1'b1;
        end
    end

    assign Aload       = ctl.aload;
    assign Bload       = ctl.bload;
    assign IRload      = ctl.irload;
    assign PCload      = ctl.pcload;
    assign ANSload     = ctl.ansload;
    assign JSM         = ctl.jsm;
    assign A_select    = ctl.a_select;
    assign B_select    = ctl.b_select;
    assign select_mode = ctl.select_mode;
    assign Busy        = ctl.busy;
    assign Halted      = ctl.halted;

endmodule

// File: tb/tb_cpu_control_unit.sv
// tb_cpu_control_unit: random and directed programs against a per-instruction cycle model
module tb_cpu_control_unit;

    localparam logic [13:0] AL = 14'h0001, BL = 14'h0002, IR = 14'h0004, PC = 14'h0008;
    localparam logic [13:0] ANS = 14'h0010, JS = 14'h0020, AS = 14'h0040, BS = 14'h0080;
    localparam logic [13:0] SM = 14'h0100, BUSY = 14'h0800, HLT = 14'h1000, ILL = 14'h2000;

    logic       clk = 0, rst0 = 1, rst1 = 1, run = 0, step = 0;
    logic [3:0] ircu = 0;
    bit         sel = 0;
    int         fw = 0;
    int         n_chk = 0, n_fail = 0;
    wire [13:0] v0, v1;
    logic [13:0] obs;

    logic [13:0] exp_q[$];
    logic [3:0]  ir_q[$];
    logic        run_q[$], stp_q[$];
    logic [3:0]  prog[$];

    always #5 clk = ~clk;
    assign obs = sel ? v1 : v0;

    cpu_control_unit #(.FETCH_WAIT(0)) u_dut0 (
        .Clk(clk), .Reset(rst0), .Run(run),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .Step(step),
`endif
        .IRCU(ircu), .mode(v0[10:9]), .Aload(v0[0]), .Bload(v0[1]), .IRload(v0[2]),
        .PCload(v0[3]), .ANSload(v0[4]), .JSM(v0[5]), .A_select(v0[6]), .B_select(v0[7]),
        .select_mode(v0[8]), .Busy(v0[11]), .Halted(v0[12]), .Illegal(v0[13])
    );

    cpu_control_unit #(.FETCH_WAIT(3)) u_dut1 (
        .Clk(clk), .Reset(rst1), .Run(run),
`ifdef CPU_CTRL_SINGLE_STEP_EN
        .Step(step),
`endif
        .IRCU(ircu), .mode(v1[10:9]), .Aload(v1[0]), .Bload(v1[1]), .IRload(v1[2]),
        .PCload(v1[3]), .ANSload(v1[4]), .JSM(v1[5]), .A_select(v1[6]), .B_select(v1[7]),
        .select_mode(v1[8]), .Busy(v1[11]), .Halted(v1[12]), .Illegal(v1[13])
    );

    task automatic check(input string tag, input logic [13:0] got, input logic [13:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s got %h want %h", tag, got, want);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [3:0] rop();
        return 4'($urandom_range(0, 15));
    endfunction

    task automatic add(input logic [13:0] v, input logic [3:0] i, input logic r, input logic s);
        exp_q.push_back(v);
        ir_q.push_back(i);
        run_q.push_back(r);
        stp_q.push_back(s);
    endtask

    // Expand the program into one expected strobe vector per clock, straight from the instruction timing rules
    task automatic build();
        logic [13:0] ill = 0, md;
        exp_q.delete(); ir_q.delete(); run_q.delete(); stp_q.delete();
        add(14'h0, rop(), 1'b1, rb());
        foreach (prog[k]) begin
            logic [3:0] o = prog[k];
`ifdef CPU_CTRL_SINGLE_STEP_EN
            add(BUSY | ill, rop(), rb(), 1'b0);
            add(BUSY | ill, rop(), rb(), 1'b1);
`endif
            add(IR | PC | BUSY | ill, rop(), rb(), rb());
            repeat (fw) add(BUSY | ill, rop(), rb(), rb());
            add(BUSY | ill, o, rb(), rb());
            if (o > 4'h7 && o != 4'hF) ill = ILL;
            md = 14'(o - 4'd3) << 9;
            if (o == 4'h1) add(AL | AS | BUSY | ill, rop(), rb(), rb());
            if (o == 4'h2) add(BL | BS | BUSY | ill, rop(), rb(), rb());
            if (o >= 4'h3 && o <= 4'h6) begin
                add(ANS | SM | md | BUSY | ill, rop(), rb(), rb());
                add(AL | SM | md | BUSY | ill, rop(), rb(), rb());
            end
            if (o == 4'h7) add(PC | JS | BUSY | ill, rop(), rb(), rb());
            if (o == 4'hF) begin
                repeat (4) add(HLT | ill, rop(), rb(), rb());
                break;
            end
        end
    endtask

    task automatic run_trace(input bit abort_exec);
        foreach (exp_q[i]) begin
            @(negedge clk);
            check($sformatf("dut%0d cyc%0d", sel, i), obs, exp_q[i]);
            if (abort_exec && exp_q[i][4]) break;
            run  = run_q[i];
            ircu = ir_q[i];
            step = stp_q[i];
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        if (sel) rst1 = 1; else rst0 = 1;
        run = 0;
        repeat (2) @(negedge clk);
        if (sel) rst1 = 0; else rst0 = 0;
        check($sformatf("dut%0d reset", sel), obs, 14'h0);
        repeat (3) begin
            @(negedge clk);
            check($sformatf("dut%0d idle", sel), obs, 14'h0);
        end
    endtask

    task automatic go(input bit abort_exec);
        build();
        run_trace(abort_exec);
        do_reset();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            rst0 = 1; rst1 = 1;
            sel = d[0];
            fw = d ? 3 : 0;
            do_reset();
            prog = '{4'h1, 4'h2, 4'h3, 4'hF};            go(1'b0);
            prog = '{4'h1, 4'h2, 4'h4, 4'hF};            go(1'b0);
            prog = '{4'h7, 4'h0, 4'h9, 4'h1, 4'hF};      go(1'b0);
            prog = '{4'hE, 4'h1, 4'h2, 4'h6, 4'hF};      go(1'b1);
            prog = '{4'h1, 4'h2, 4'h5, 4'hF};            go(1'b0);
            for (int t = 0; t < 8; t++) begin
                prog.delete();
                repeat ($urandom_range(3, 10)) prog.push_back(4'($urandom_range(0, 14)));
                prog.push_back(4'hF);
                go(1'b0);
            end
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
